// File: rtl/spell_pkg.sv
// Shared definitions for the spell core's RAM-bus responder.
package spell_pkg;

    // Responder FSM states; the encoding is visible to anything that probes busy/state.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2,
        StDone = 2'd3
    } rambus_state_t;

    // Default word count of the shared RAM.
    localparam int unsigned RAMBUS_WORDS = 256;

endpackage

// File: rtl/spell_rambus_bytemem.sv
// Synchronous single-port RAM, 32-bit words with per-byte write enables.
// Read-first: rdata returns the pre-write contents of addr.
module spell_rambus_bytemem #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clock,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [31:0] mem [0:DEPTH-1];

    // Byte-lane writes and registered read, one access port.
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/spell_rambus_ram.sv
// Wishbone-classic responder for the spell core's shared RAM bus.
// Idle -> Wait (WAIT_STATES cycles) -> Ack (one-cycle ack) -> Done (stb ignored) -> Idle.
module spell_rambus_ram
    import spell_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ADDR_W      = $clog2(RAMBUS_WORDS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [31:0]       wb_dat_i,
    output logic              wb_ack_o,
    output logic [31:0]       wb_dat_o,
    output logic              busy_o
);

    localparam bit         NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    rambus_state_t     state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       dat_q;
    logic [31:0]       rd_hold_q;

    logic              req;
    logic              enter_ack;
    logic              acc_we;
    logic [3:0]        acc_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_we;
    logic [31:0]       mem_rdata;

    assign req = wb_cyc_i && wb_stb_i;

    // State and wait-counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Request fields are captured only at acceptance; later input changes are ignored.
    always_ff @(posedge clock) begin
        if (state_q == StIdle && req) begin
            we_q   <= wb_we_i;
            sel_q  <= wb_sel_i;
            addr_q <= wb_addr_i;
            dat_q  <= wb_dat_i;
        end
    end

    // Next-state: count down the wait states, abort on cyc/stb loss, Done swallows a held stb.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (NO_WAIT) begin
                        state_d = StAck;
                    end else begin
                        state_d    = StWait;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
            StWait: begin
                if (!req) begin
                    state_d = StIdle;
                end else if (wait_cnt_q == 4'd0) begin
                    state_d = StAck;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StAck:  state_d = StDone;
            StDone: state_d = StIdle;
        endcase
    end

    // Memory access happens on the Ack-entry edge; with no wait states that edge is the
    // acceptance edge, so the live bus fields are used while still in Idle.
    always_comb begin
        acc_we    = (state_q == StIdle) ? wb_we_i   : we_q;
        acc_sel   = (state_q == StIdle) ? wb_sel_i  : sel_q;
        mem_addr  = (state_q == StIdle) ? wb_addr_i : addr_q;
        mem_wdata = (state_q == StIdle) ? wb_dat_i  : dat_q;
        enter_ack = !reset && (state_q != StAck) && (state_d == StAck);
        mem_we    = (enter_ack && acc_we) ? acc_sel : 4'b0000;
    end

    spell_rambus_bytemem #(
        .ADDR_W (ADDR_W)
    ) u_bytemem (
        .clock (clock),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Keep the last read word so wb_dat_o is stable across writes and idle cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_hold_q <= 32'd0;
        end else if (state_q == StAck && !we_q) begin
            rd_hold_q <= mem_rdata;
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        wb_ack_o = (state_q == StAck);
        busy_o   = (state_q != StIdle);
        wb_dat_o = (state_q == StAck && !we_q) ? mem_rdata : rd_hold_q;
    end

endmodule

// File: tb/tb_spell_rambus_ram.sv
// Scoreboard bench: three responders (WAIT_STATES 1, 3, 0) share clock and reset.
// Stimulus pushes expected acks (cycle, data) into a queue; a negedge monitor pops them.
module tb_spell_rambus_ram;

    localparam int NI = 3;

    typedef struct {
        int          inst;
        bit          is_read;
        logic [31:0] data;
        int          ack_cycle;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NI-1:0]   cyc = '0;
    logic [NI-1:0]   stb = '0;
    logic [NI-1:0]   we = '0;
    logic [NI-1:0]   ack;
    logic [NI-1:0]   busy;
    logic [3:0]      sel  [NI];
    logic [7:0]      addr [NI];
    logic [31:0]     wdat [NI];
    logic [31:0]     rdat [NI];

    logic [31:0]     model     [NI][256];
    logic [31:0]     last_read [NI];
    exp_t            exp_q [$];
    int              cyc_cnt = 0;
    int              n_checks = 0;
    int              n_fail = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    spell_rambus_ram #(.WAIT_STATES(1)) u_dut0 (
        .clock(clock), .reset(reset), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
        .wb_sel_i(sel[0]), .wb_addr_i(addr[0]), .wb_dat_i(wdat[0]), .wb_ack_o(ack[0]),
        .wb_dat_o(rdat[0]), .busy_o(busy[0])
    );
    spell_rambus_ram #(.WAIT_STATES(3)) u_dut1 (
        .clock(clock), .reset(reset), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
        .wb_sel_i(sel[1]), .wb_addr_i(addr[1]), .wb_dat_i(wdat[1]), .wb_ack_o(ack[1]),
        .wb_dat_o(rdat[1]), .busy_o(busy[1])
    );
    spell_rambus_ram #(.WAIT_STATES(0)) u_dut2 (
        .clock(clock), .reset(reset), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we[2]),
        .wb_sel_i(sel[2]), .wb_addr_i(addr[2]), .wb_dat_i(wdat[2]), .wb_ack_o(ack[2]),
        .wb_dat_o(rdat[2]), .busy_o(busy[2])
    );

    function automatic int ws_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc_cnt);
        end
    endfunction

    // Monitor: every ack must match the head of the scoreboard in instance, cycle and data.
    always @(negedge clock) begin : monitor
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            if (ack[k] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: inst %0d ack at cycle %0d, required none",
                             k, cyc_cnt);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_inst", k, e.inst);
                    check("ack_cycle", cyc_cnt, e.ack_cycle);
                    check(e.is_read ? "read_data" : "held_dat_on_write", rdat[k], e.data);
                end
            end
        end
    end

    // Reference: a write merges selected bytes; a read returns the word and becomes the held value.
    function automatic void model_access(input int k, input bit w, input logic [3:0] s,
                                         input logic [7:0] a, input logic [31:0] d,
                                         output logic [31:0] resp);
        if (w) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[k][a][8*b +: 8] = d[8*b +: 8];
            end
            resp = last_read[k];
        end else begin
            resp = model[k][a];
            last_read[k] = resp;
        end
    endfunction

    // Called at a negedge with the responder in Idle; returns at a negedge back in Idle.
    task automatic issue(input int k, input bit w, input logic [3:0] s, input logic [7:0] a,
                         input logic [31:0] d, input bit scramble);
        exp_t e;
        bit   got;
        e.inst      = k;
        e.is_read   = !w;
        e.ack_cycle = cyc_cnt + 1 + ws_of(k);
        model_access(k, w, s, a, d, e.data);
        exp_q.push_back(e);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; addr[k] = a; wdat[k] = d;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (ack[k]) begin
                got = 1'b1;
            end else if (scramble) begin
                // Request already accepted: these must not leak into the transfer.
                we[k] = 1'($urandom); sel[k] = 4'($urandom);
                addr[k] = 8'($urandom); wdat[k] = $urandom;
            end
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: inst %0d no ack within 40 cycles, required one", k);
        end
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic held_strobe();
        exp_t e;
        bit   got;
        int   a_cyc;
        e.inst      = 0;
        e.is_read   = 1'b0;
        a_cyc       = cyc_cnt + 1 + ws_of(0);
        e.ack_cycle = a_cyc;
        model_access(0, 1'b1, 4'hF, 8'h01, 32'd1, e.data);
        exp_q.push_back(e);
        // A held strobe is re-accepted only after Done and Idle: one transfer per WS+3 cycles.
        e.ack_cycle = a_cyc + ws_of(0) + 3;
        exp_q.push_back(e);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF; addr[0] = 8'h01;
        wdat[0] = 32'd1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (ack[0]) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL held_ack_timeout: no ack within 40 cycles, required one");
        end
        repeat (4) @(negedge clock);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic abort_write();
        logic [31:0] prior;
        prior = model[1][8'h40];
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; addr[1] = 8'h40;
        wdat[1] = 32'h55;
        @(negedge clock);
        @(negedge clock);
        cyc[1] = 1'b0;
        @(negedge clock);
        stb[1] = 1'b0;
        check("abort_busy", 32'(busy[1]), 32'd0);
        @(negedge clock);
        issue(1, 1'b0, 4'h0, 8'h40, 32'h0, 1'b0);
        check("abort_model_unchanged", model[1][8'h40], prior);
    endtask

    task automatic reset_mid_write();
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF; addr[0] = 8'h80;
        wdat[0] = 32'hCAFEF00D;
        @(negedge clock);
        check("rst_pre_busy", 32'(busy[0]), 32'd1);
        reset = 1'b1; cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clock);
        check("rst_ack", 32'(ack[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_dat", rdat[0], 32'd0);
        reset = 1'b0;
        for (int k = 0; k < NI; k++) last_read[k] = 32'd0;
        @(negedge clock);
        issue(0, 1'b0, 4'h0, 8'h80, 32'h0, 1'b0);
        issue(0, 1'b0, 4'h0, 8'h12, 32'h0, 1'b0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        for (int k = 0; k < NI; k++) begin
            sel[k] = '0; addr[k] = '0; wdat[k] = '0; last_read[k] = '0;
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < NI; k++) begin
            check("reset_ack", 32'(ack[k]), 32'd0);
            check("reset_busy", 32'(busy[k]), 32'd0);
            check("reset_dat", rdat[k], 32'd0);
        end

        // Give every word a known value so later reads have a defined expectation.
        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < 256; a++) issue(k, 1'b1, 4'hF, 8'(a), $urandom, 1'b1);
        end

        // Directed: full write, byte lanes, empty select.
        issue(0, 1'b1, 4'hF, 8'h12, 32'hDEADBEEF, 1'b1);
        issue(0, 1'b0, 4'h0, 8'h12, 32'h0, 1'b1);
        check("model_deadbeef", last_read[0], 32'hDEADBEEF);
        issue(0, 1'b1, 4'b0101, 8'h12, 32'h11223344, 1'b1);
        issue(0, 1'b0, 4'hA, 8'h12, 32'h0, 1'b1);
        issue(0, 1'b1, 4'b0000, 8'h12, 32'h99999999, 1'b1);
        issue(0, 1'b0, 4'h0, 8'h12, 32'h0, 1'b1);
        check("model_lanes", last_read[0], 32'hDE22BE44);

        held_strobe();
        issue(0, 1'b0, 4'h0, 8'h01, 32'h0, 1'b0);

        abort_write();
        reset_mid_write();

        // No wait states, address extremes.
        issue(2, 1'b1, 4'hF, 8'hFF, 32'hA5A5A5A5, 1'b1);
        issue(2, 1'b1, 4'hF, 8'h00, 32'h5A5A5A5A, 1'b1);
        issue(2, 1'b0, 4'h0, 8'hFF, 32'h0, 1'b1);
        issue(2, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1);

        // Random traffic on every instance.
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 80; i++) begin
                issue(k, 1'($urandom), 4'($urandom), 8'($urandom), $urandom, 1'b1);
            end
        end

        repeat (10) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
